soc_ctrl_domain_seq: RTL



---
 rtl/soc_ctrl_pkg.sv | 20 ++
 rtl/soc_ctrl_counter.sv | 36 +++
 rtl/soc_ctrl_domain_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/soc_ctrl_pkg.sv
// Shared types and helpers for the soc_ctrl domain power sequencer.
// Holds the sequencer state encoding and the delay-counter width helper.
// No datapath here, so no latency and no backpressure.
package soc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP_RST = 3'd1,
    UP_CLK = 3'd2,
    ON     = 3'd3,
    DN_CLK = 3'd4,
    DN_RST = 3'd5
  } domain_seq_state_e;

  // Bits needed to hold 0..delay.
  function automatic int unsigned cnt_width(input int unsigned delay);
    return (delay > 0) ? $clog2(delay + 1) : 1;
  endfunction

endpackage

// File: rtl/soc_ctrl_counter.sv
// Up-counter with synchronous clear that saturates at MAX.
// The count updates one clk_i edge after en_i; clr_i wins over en_i.
// There is no backpressure: once it reaches MAX, the count holds there.
module soc_ctrl_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != WIDTH'(MAX))) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/soc_ctrl_domain_seq.sv
// Domain power sequencer: ordered reset release and clock enable on power-up, reverse order on power-down.
// Steps are DELAY_CYCLES apart and all outputs are registered. Requests are level-sensitive and have no backpressure.
// Defining SOC_CTRL_DOMAIN_SEQ_STATUS_EN adds the state_o and idx_o status outputs.
module soc_ctrl_domain_seq
  import soc_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS  = 4,
  parameter int unsigned DELAY_CYCLES = 50,
  parameter int unsigned IDX_W        = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1,
  parameter int unsigned CNT_W        = cnt_width(DELAY_CYCLES)
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic [NUM_DOMAINS-1:0] dom_arst_no,
  output logic [NUM_DOMAINS-1:0] dom_clk_en_o,
  output logic                   busy_o,
  output logic                   up_o
`ifdef SOC_CTRL_DOMAIN_SEQ_STATUS_EN
  ,
  output logic [2:0]             state_o,
  output logic [IDX_W-1:0]       idx_o
`endif
);

  domain_seq_state_e       state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    stop_pend_q, stop_pend_d;
  logic [NUM_DOMAINS-1:0]  rst_n_q, rst_n_d;
  logic [NUM_DOMAINS-1:0]  clk_en_q, clk_en_d;
  logic                    busy_q, busy_d;
  logic                    up_q, up_d;

  logic                    cnt_clr, cnt_en, step;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx_inc, idx_dec;

  soc_ctrl_counter #(
    .WIDTH (CNT_W),
    .MAX   (DELAY_CYCLES - 1)
  ) u_delay_cnt (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt)
  );

  assign step    = (cnt == CNT_W'(DELAY_CYCLES - 1));
  assign idx_inc = idx_q + IDX_W'(1);
  assign idx_dec = idx_q - IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stop_pend_d = stop_pend_q;
    rst_n_d     = rst_n_q;
    clk_en_d    = clk_en_q;
    busy_d      = busy_q;
    up_d        = up_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    // Sequencing states time each step with the counter; a firing step restarts it.
    if (state_q inside {UP_RST, UP_CLK, DN_CLK, DN_RST}) begin
      cnt_en  = ~step;
      cnt_clr = step;
    end else begin
      cnt_clr = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          rst_n_d[0] = 1'b1;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = UP_RST;
        end
      end
      UP_RST: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (step) begin
          clk_en_d[idx_q] = 1'b1;
          state_d         = UP_CLK;
        end
      end
      UP_CLK: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (step) begin
          if (idx_q < IDX_W'(NUM_DOMAINS - 1)) begin
            idx_d            = idx_inc;
            rst_n_d[idx_inc] = 1'b1;
            state_d          = UP_RST;
          end else begin
            up_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = ON;
          end
        end
      end
      ON: begin
        if (stop_i || stop_pend_q) begin
          up_d                       = 1'b0;
          busy_d                     = 1'b1;
          stop_pend_d                = 1'b0;
          idx_d                      = IDX_W'(NUM_DOMAINS - 1);
          clk_en_d[NUM_DOMAINS - 1]  = 1'b0;
          state_d                    = DN_CLK;
        end
      end
      DN_CLK: begin
        if (step) begin
          rst_n_d[idx_q] = 1'b0;
          state_d        = DN_RST;
        end
      end
      DN_RST: begin
        if (step) begin
          if (idx_q != '0) begin
            idx_d             = idx_dec;
            clk_en_d[idx_dec] = 1'b0;
            state_d           = DN_CLK;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      stop_pend_q <= 1'b0;
      rst_n_q     <= '0;
      clk_en_q    <= '0;
      busy_q      <= 1'b0;
      up_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stop_pend_q <= stop_pend_d;
      rst_n_q     <= rst_n_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      up_q        <= up_d;
    end
  end

  assign dom_arst_no  = rst_n_q;
  assign dom_clk_en_o = clk_en_q;
  assign busy_o       = busy_q;
  assign up_o         = up_q;

`ifdef SOC_CTRL_DOMAIN_SEQ_STATUS_EN
  assign state_o = state_q;
  assign idx_o   = idx_q;
`endif

endmodule
